// File: rtl/systolic_pkg.sv
// Shared definitions for the 3x3 systolic matrix multiplier and its result drain.
// Holds the default geometry, the Q6.10 format constants and the drain FSM states.
package systolic_pkg;

    localparam int DEF_DATA_W        = 16;
    localparam int DEF_N             = 3;
    localparam int DEF_SETTLE_CYCLES = 8;

    // Q6.10 two's complement accumulator format
    localparam int Q_INT_BITS  = 6;
    localparam int Q_FRAC_BITS = 10;

    localparam int TIMER_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        DRAIN
    } drain_state_t;

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter with a zero flag; same pattern as the operand sequencer.
// Ports: clk, reset (sync, active-high), load/load_val, en (decrement), done (count==0).
module settle_timer
    import systolic_pkg::*;
#(
    parameter int W = TIMER_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/systolic_result_drain.sv
// Result drain for the systolic array: waits out the settle time after start,
// snapshots all N*N accumulators, pulses clr_acc, then streams results row-major.
// Ports: clk, reset (sync, active-high), start, acc_flat (N*N words),
//        clr_acc, busy, m_valid/m_ready/m_data/m_index/m_last stream.
module systolic_result_drain
    import systolic_pkg::*;
#(
    parameter int DATA_W        = DEF_DATA_W,
    parameter int N             = DEF_N,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [N*N*DATA_W-1:0]     acc_flat,
    output logic                      clr_acc,
    output logic                      busy,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [DATA_W-1:0]         m_data,
    output logic [$clog2(N*N)-1:0]    m_index,
    output logic                      m_last
);

    localparam int IDX_W = $clog2(N*N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N*N - 1);

    drain_state_t             state;
    logic [IDX_W-1:0]         idx;
    logic [N*N*DATA_W-1:0]    bank;
    logic                     tmr_load;
    logic                     tmr_en;
    logic                     tmr_done;

    assign tmr_load = (state == IDLE) && start;
    assign tmr_en   = (state == SETTLE);

    settle_timer #(
        .W (TIMER_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (TIMER_W'(SETTLE_CYCLES - 1)),
        .en       (tmr_en),
        .done     (tmr_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            bank  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (tmr_done) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    bank  <= acc_flat;
                    idx   <= '0;
                    state <= DRAIN;
                end
                DRAIN: begin
                    if (m_ready) begin
                        // idx parks at 0 so the next pass starts clean
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= IDLE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign clr_acc = (state == CAPTURE);
    assign busy    = (state != IDLE);
    assign m_valid = (state == DRAIN);
    assign m_index = idx;
    assign m_last  = m_valid && (idx == LAST_IDX);
    // Gated so the data bus reads zero whenever no word is offered
    assign m_data  = m_valid ? bank[int'(idx)*DATA_W +: DATA_W] : '0;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Scoreboard bench for systolic_result_drain: one task per scenario,
// expected beats queued at start and checked on each handshake.
module tb_systolic_result_drain;

    localparam int DW  = 16;
    localparam int NN  = 3;
    localparam int NW  = NN*NN;
    localparam int IW  = 4;
    localparam int SC  = 8;
    localparam int SC1 = 1;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic              start = 1'b0;
    logic              m_ready = 1'b0;
    logic [NW*DW-1:0]  acc_flat = '0;
    logic              clr_acc, busy, m_valid, m_last;
    logic [DW-1:0]     m_data;
    logic [IW-1:0]     m_index;

    logic              s1_start = 1'b0;
    logic              s1_ready = 1'b0;
    logic [NW*DW-1:0]  s1_acc = '0;
    logic              s1_clr, s1_busy, s1_valid, s1_last;
    logic [DW-1:0]     s1_data;
    logic [IW-1:0]     s1_index;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [IW-1:0] idx;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    beat_t e;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    systolic_result_drain #(
        .DATA_W (DW), .N (NN), .SETTLE_CYCLES (SC)
    ) dut (
        .clk (clk), .reset (reset), .start (start),
        .acc_flat (acc_flat), .clr_acc (clr_acc), .busy (busy),
        .m_valid (m_valid), .m_ready (m_ready), .m_data (m_data),
        .m_index (m_index), .m_last (m_last)
    );

    systolic_result_drain #(
        .DATA_W (DW), .N (NN), .SETTLE_CYCLES (SC1)
    ) dut1 (
        .clk (clk), .reset (reset), .start (s1_start),
        .acc_flat (s1_acc), .clr_acc (s1_clr), .busy (s1_busy),
        .m_valid (s1_valid), .m_ready (s1_ready), .m_data (s1_data),
        .m_index (s1_index), .m_last (s1_last)
    );

    function automatic logic [NW*DW-1:0] ramp();
        logic [NW*DW-1:0] v;
        for (int i = 0; i < NW; i++) v[i*DW +: DW] = 16'((i + 1) * 1024);
        return v;
    endfunction

    function automatic void push_pass(input logic [NW*DW-1:0] a);
        beat_t b;
        for (int i = 0; i < NW; i++) begin
            b.data = a[i*DW +: DW];
            b.idx  = IW'(i);
            b.last = (i == NW - 1);
            exp_q.push_back(b);
        end
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        s1_start = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        s1_start = 1'b0;
        vectors++;
        if ({clr_acc, busy, m_valid, m_data, m_index, m_last} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got %b/%b/%b/%h/%h/%b want all 0",
                     clr_acc, busy, m_valid, m_data, m_index, m_last);
        end
        vectors++;
        if ({s1_clr, s1_busy, s1_valid, s1_data, s1_index, s1_last} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs_s1 got nonzero outputs");
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || s1_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_start_lost busy=%b s1_busy=%b want 0", busy, s1_busy);
        end
    endtask

    task automatic test_basic();
        acc_flat = ramp();
        m_ready = 1'b1;
        exp_q.delete();
        push_pass(acc_flat);
        start = 1'b1;
        for (int c = 1; c <= SC + NW + 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            vectors++;
            if (clr_acc !== 1'(c == SC + 1)) begin
                miscompares++;
                $display("FAIL basic_clr c=%0d got %b want %b", c, clr_acc, c == SC + 1);
            end
            vectors++;
            if (busy !== 1'(c <= SC + 1 + NW)) begin
                miscompares++;
                $display("FAIL basic_busy c=%0d got %b want %b", c, busy, c <= SC + 1 + NW);
            end
            vectors++;
            if (m_valid !== 1'(c >= SC + 2 && c <= SC + 1 + NW)) begin
                miscompares++;
                $display("FAIL basic_valid c=%0d got %b", c, m_valid);
            end
            if (m_valid && m_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL basic_extra_beat c=%0d got idx %0d want none", c, m_index);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_data, m_index, m_last} !== e) begin
                        miscompares++;
                        $display("FAIL basic_beat got %h/%0d/%b want %h/%0d/%b",
                                 m_data, m_index, m_last, e.data, e.idx, e.last);
                    end
                end
            end
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL basic_missing got %0d left want 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        int stall = 0;
        int beats = 0;
        acc_flat = ramp();
        m_ready = 1'b1;
        exp_q.delete();
        push_pass(acc_flat);
        start = 1'b1;
        for (int c = 1; c <= SC + NW + 8; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (m_valid && m_index == 4'd4 && stall < 3) begin
                m_ready = 1'b0;
                stall++;
            end else begin
                m_ready = 1'b1;
            end
            if (m_valid && !m_ready) begin
                vectors++;
                if (m_data !== 16'h1400 || m_index !== 4'd4 || m_last !== 1'b0) begin
                    miscompares++;
                    $display("FAIL bp_hold got %h/%0d/%b want 1400/4/0",
                             m_data, m_index, m_last);
                end
            end
            if (m_valid && m_ready) begin
                beats++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL bp_extra_beat got idx %0d want none", m_index);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_data, m_index, m_last} !== e) begin
                        miscompares++;
                        $display("FAIL bp_beat got %h/%0d/%b want %h/%0d/%b",
                                 m_data, m_index, m_last, e.data, e.idx, e.last);
                    end
                end
            end
        end
        m_ready = 1'b1;
        vectors++;
        if (beats != NW || stall != 3) begin
            miscompares++;
            $display("FAIL bp_count got beats=%0d stalls=%0d want 9/3", beats, stall);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_idle got busy=%b want 0", busy);
        end
    endtask

    task automatic test_snapshot();
        logic [NW*DW-1:0] a;
        for (int i = 0; i < NW; i++) a[i*DW +: DW] = 16'(i * 16'h1357 + 16'h0ace);
        acc_flat = a;
        m_ready = 1'b1;
        exp_q.delete();
        push_pass(a);
        start = 1'b1;
        for (int c = 1; c <= SC + NW + 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == SC + 2) acc_flat = '1;
            if (m_valid && m_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL snap_extra_beat got idx %0d want none", m_index);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_data, m_index, m_last} !== e) begin
                        miscompares++;
                        $display("FAIL snap_beat got %h/%0d want %h/%0d",
                                 m_data, m_index, e.data, e.idx);
                    end
                end
            end
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL snap_missing got %0d left want 0", exp_q.size());
        end
    endtask

    task automatic test_start_busy();
        int clr_n = 0;
        int beats = 0;
        acc_flat = ramp();
        m_ready = 1'b1;
        exp_q.delete();
        push_pass(acc_flat);
        start = 1'b1;
        for (int c = 1; c <= SC + NW + 15; c++) begin
            @(negedge clk);
            start = (c == 3) || (c == SC + 4);
            if (clr_acc) clr_n++;
            vectors++;
            if (busy !== 1'(c <= SC + 1 + NW)) begin
                miscompares++;
                $display("FAIL sb_busy c=%0d got %b want %b", c, busy, c <= SC + 1 + NW);
            end
            if (m_valid && m_ready) begin
                beats++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_extra_beat got idx %0d want none", m_index);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_data, m_index, m_last} !== e) begin
                        miscompares++;
                        $display("FAIL sb_beat got %h/%0d want %h/%0d",
                                 m_data, m_index, e.data, e.idx);
                    end
                end
            end
        end
        start = 1'b0;
        vectors++;
        if (clr_n != 1 || beats != NW) begin
            miscompares++;
            $display("FAIL sb_count got clr=%0d beats=%0d want 1/9", clr_n, beats);
        end
    endtask

    task automatic test_reset_mid();
        int hs = 0;
        int first_c = -1;
        acc_flat = ramp();
        m_ready = 1'b1;
        exp_q.delete();
        start = 1'b1;
        for (int c = 1; c <= SC + NW + 4 && hs < 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (m_valid && m_ready) hs++;
        end
        vectors++;
        if (hs != 4) begin
            miscompares++;
            $display("FAIL rm_reach got %0d handshakes want 4", hs);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vectors++;
        if ({clr_acc, busy, m_valid, m_data, m_index, m_last} !== '0) begin
            miscompares++;
            $display("FAIL rm_outputs got %b/%b/%b/%h/%h/%b want all 0",
                     clr_acc, busy, m_valid, m_data, m_index, m_last);
        end
        push_pass(acc_flat);
        start = 1'b1;
        for (int c = 1; c <= SC + NW + 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (m_valid && first_c < 0) begin
                first_c = c;
                vectors++;
                if (m_index !== 4'd0) begin
                    miscompares++;
                    $display("FAIL rm_first_idx got %0d want 0", m_index);
                end
            end
            if (m_valid && m_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rm_extra_beat got idx %0d want none", m_index);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_data, m_index, m_last} !== e) begin
                        miscompares++;
                        $display("FAIL rm_beat got %h/%0d want %h/%0d",
                                 m_data, m_index, e.data, e.idx);
                    end
                end
            end
        end
        vectors++;
        if (first_c != SC + 2) begin
            miscompares++;
            $display("FAIL rm_first_valid got cycle %0d want %0d", first_c, SC + 2);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL rm_missing got %0d left want 0", exp_q.size());
        end
    endtask

    task automatic test_settle1();
        logic [NW*DW-1:0] a;
        logic [DW-1:0] tbl [NW] = '{16'hf800, 16'h8000, 16'h7fff, 16'hffff,
                                    16'h0001, 16'h0400, 16'hfc00, 16'h1234, 16'h8001};
        for (int i = 0; i < NW; i++) a[i*DW +: DW] = tbl[i];
        s1_acc = a;
        s1_ready = 1'b1;
        exp_q.delete();
        push_pass(a);
        s1_start = 1'b1;
        for (int c = 1; c <= SC1 + NW + 3; c++) begin
            @(negedge clk);
            s1_start = 1'b0;
            vectors++;
            if (s1_clr !== 1'(c == SC1 + 1)) begin
                miscompares++;
                $display("FAIL s1_clr c=%0d got %b want %b", c, s1_clr, c == SC1 + 1);
            end
            vectors++;
            if (s1_valid !== 1'(c >= SC1 + 2 && c <= SC1 + 1 + NW)) begin
                miscompares++;
                $display("FAIL s1_valid c=%0d got %b", c, s1_valid);
            end
            if (s1_valid && s1_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL s1_extra_beat got idx %0d want none", s1_index);
                end else begin
                    e = exp_q.pop_front();
                    if ({s1_data, s1_index, s1_last} !== e) begin
                        miscompares++;
                        $display("FAIL s1_beat got %h/%0d/%b want %h/%0d/%b",
                                 s1_data, s1_index, s1_last, e.data, e.idx, e.last);
                    end
                end
            end
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL s1_missing got %0d left want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        repeat (2) @(negedge clk);
        test_backpressure();
        repeat (2) @(negedge clk);
        test_snapshot();
        repeat (2) @(negedge clk);
        test_start_busy();
        repeat (2) @(negedge clk);
        test_reset_mid();
        repeat (2) @(negedge clk);
        test_settle1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

endmodule

// File: doc/systolic_result_drain.md
# systolic_result_drain

Result-side companion to the 3x3 systolic matrix multiplier. It tracks one matrix-multiply pass from its `start` pulse and waits a fixed settle time while the skewed operands propagate through the MAC grid. It then snapshots all N×N Q6.10 accumulators in one cycle, pulses a clear back to the array, and streams the results row-major over a valid/ready interface with index and last-beat tags.

## Interface
Parameters:
- `DATA_W`, 16: width of one accumulator / output word, Q6.10 two's complement.
- `N`, 3: array dimension; N*N results per pass.
- `SETTLE_CYCLES`, 8: cycles from accepted `start` until the accumulators are final; legal range 1..255.

Ports:
- `clk`, in, 1: clock, all state on rising edge.
- `reset`, in, 1: reset, synchronous, active-high.
- `start`, in, 1: one-cycle pulse, same cycle the array's operand sequencer is started.
- `acc_flat`, in, N*N*DATA_W: accumulator (r,c) at bits [(r*N+c)*DATA_W +: DATA_W].
- `clr_acc`, out, 1: one-cycle pulse to clear array accumulators.
- `busy`, out, 1: high in every state except IDLE.
- `m_valid`, out, 1: output word valid.
- `m_ready`, in, 1: downstream accepts word.
- `m_data`, out, DATA_W: current result word.
- `m_index`, out, $clog2(N*N): row-major index r*N+c of `m_data`.
- `m_last`, out, 1: high with the final word (index N*N-1).

## Operation
- FSM states: IDLE, SETTLE, CAPTURE, DRAIN.
- IDLE + `start` → SETTLE. The settle counter loads SETTLE_CYCLES-1.
- SETTLE: counter decrements each cycle. When counter==0 → CAPTURE.
- CAPTURE, exactly one cycle:
  - Registers all of `acc_flat` into an N*N×DATA_W result bank.
  - Asserts `clr_acc`.
  - Clears the read index to 0.
  - → DRAIN.
- DRAIN:
  - `m_valid`=1, `m_data`=bank[idx], `m_index`=idx, `m_last`=(idx==N*N-1).
  - On `m_valid && m_ready`: idx increments. If that beat was the last → IDLE.
- `start` outside IDLE is ignored; no queuing, no error flag.
- Backpressure: while `m_valid && !m_ready`, `m_data`, `m_index` and `m_last` hold stable. The bank never changes outside CAPTURE.
- Data is passed bit-exact; no rounding, saturation or sign handling.
- Reset values: state IDLE, counter 0, idx 0, bank all zero. All outputs 0: `clr_acc`, `busy`, `m_valid`, `m_data`, `m_index`, `m_last`.
- Reset mid-operation (any state) aborts the pass immediately. A partially drained stream is not resumed, and `clr_acc` is not issued.
- Reset and `start` in the same cycle: reset wins; `start` is lost.

## Timing
- `start` sampled high at edge k (state IDLE):
  - SETTLE occupies cycles k+1..k+SETTLE_CYCLES.
  - CAPTURE occupies cycle k+SETTLE_CYCLES+1. `acc_flat` is sampled at the end of that cycle, and `clr_acc` is high during it.
  - First `m_valid` is in cycle k+SETTLE_CYCLES+2.
- With `m_ready` tied high:
  - N*N consecutive beats.
  - `busy` falls in the cycle after the last handshake.
  - Pass length is SETTLE_CYCLES+1+N*N cycles.
- A new `start` is accepted in the first IDLE cycle, i.e. the cycle after the last handshake.
- `m_valid` does not depend combinationally on `m_ready`. Outputs are driven from registers or state decode only.
- `busy` is high from cycle k+1 through the last handshake cycle inclusive.

## Structure
- Shared package `systolic_pkg`:
  - `DATA_W`, `N`, `SETTLE_CYCLES` defaults.
  - Drain FSM state enum.
  - Q6.10 format constants (frac bits = 10).
- One natural sub-module: `settle_timer`. It is a loadable 8-bit down-counter with a `done` flag, which is the same counter pattern the operand sequencer uses.
- Result bank and index mux are inline in the top.

## Test plan
- Basic pass:
  - Stimulus: `acc_flat` (r,c) = (r*3+c+1)*1024 (0x0400..0x2400), `m_ready`=1, `start` at edge 10.
  - Required response: `clr_acc` only in cycle 19; beats in cycles 20..28 with data 0x0400,0x0800,…,0x2400 and index 0..8; `m_last` only in cycle 28; `busy` low from cycle 29.
- Backpressure:
  - Stimulus: drop `m_ready` for 3 cycles on index 4.
  - Required response: data 0x1400 and index 4 held stable for those cycles; no beat skipped or duplicated; total beats = 9.
- Snapshot isolation:
  - Stimulus: change `acc_flat` to all 0xFFFF one cycle after CAPTURE.
  - Required response: the stream still carries the captured values.
- Start while busy:
  - Stimulus: pulse `start` during SETTLE and again during DRAIN.
  - Required response: exactly one pass, 9 beats, one `clr_acc`.
- Reset mid-drain:
  - Stimulus: assert `reset` after the 4th handshake.
  - Required response: next cycle all outputs are 0 and state is IDLE. A following `start` with SETTLE_CYCLES=8 gives first valid exactly 10 cycles after the start edge, at index 0.
- SETTLE_CYCLES=1 corner:
  - Stimulus: `start` at edge k.
  - Required response: CAPTURE at k+2, first valid at k+3; negative value 0xF800 (−2.0) passes through unchanged.
